// File: rtl/cpu_pkg.sv
// Shared types and field positions for the 16-bit CPU core.
package cpu_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned REG_ADDR_W = 3;

  // Instruction field bit positions
  localparam int unsigned OP_MSB   = 15;
  localparam int unsigned OP_LSB   = 12;
  localparam int unsigned RD_MSB   = 11;
  localparam int unsigned RD_LSB   = 9;
  localparam int unsigned RS_MSB   = 8;
  localparam int unsigned RS_LSB   = 6;
  localparam int unsigned RT_MSB   = 5;
  localparam int unsigned RT_LSB   = 3;
  localparam int unsigned IMM6_MSB = 5;
  localparam int unsigned IMM8_MSB = 7;

  typedef enum logic [3:0] {
    OpNop  = 4'h0,
    OpAdd  = 4'h1,
    OpSub  = 4'h2,
    OpAnd  = 4'h3,
    OpOr   = 4'h4,
    OpXor  = 4'h5,
    OpAddi = 4'h6,
    OpLdi  = 4'h7,
    OpBz   = 4'h8,
    OpJr7  = 4'h9,
    OpHalt = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    AluAdd = 3'd0,
    AluSub = 3'd1,
    AluAnd = 3'd2,
    AluOr  = 3'd3,
    AluXor = 3'd4
  } alu_op_t;

  typedef enum logic [2:0] {
    StFetch     = 3'd0,
    StDecode    = 3'd1,
    StExecute   = 3'd2,
    StWriteback = 3'd3,
    StHalted    = 3'd4
  } state_t;

  function automatic logic [DATA_W-1:0] sext6(input logic [IMM6_MSB:0] v);
    return {{(DATA_W - IMM6_MSB - 1){v[IMM6_MSB]}}, v};
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Fetch handshake, register_file and ALU/writeback control bundle of control_unit.
interface control_unit_if
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W = 8
);
  logic [DATA_W-1:0]     instr;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [PC_W-1:0]       pc;
  logic [DATA_W-1:0]     rs_data;
  logic [DATA_W-1:0]     r7_data;
  logic [REG_ADDR_W-1:0] rs_addr;
  logic [REG_ADDR_W-1:0] rt_addr;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic                  rf_write;
  logic [2:0]            alu_op;
  logic                  alu_src_imm;
  logic                  wb_sel_imm;
  logic [DATA_W-1:0]     imm;
  logic                  halted;

  modport master (
    input  instr, instr_valid, rs_data, r7_data,
    output instr_ready, pc, rs_addr, rt_addr, rd_addr, rf_write,
           alu_op, alu_src_imm, wb_sel_imm, imm, halted
  );

  modport slave (
    output instr, instr_valid, rs_data, r7_data,
    input  instr_ready, pc, rs_addr, rt_addr, rd_addr, rf_write,
           alu_op, alu_src_imm, wb_sel_imm, imm, halted
  );
endinterface

// File: rtl/instr_decode.sv
// Combinational instruction decoder. BRANCH_EN enables BZ/JR7; otherwise they decode as NOP.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [DATA_W-1:0]     ir,
  output logic [REG_ADDR_W-1:0] rs_addr,
  output logic [REG_ADDR_W-1:0] rt_addr,
  output logic [REG_ADDR_W-1:0] rd_addr,
  output alu_op_t               alu_op,
  output logic                  alu_src_imm,
  output logic                  wb_sel_imm,
  output logic [DATA_W-1:0]     imm,
  output logic                  writes_rd,
  output logic                  is_bz,
  output logic                  is_jr7,
  output logic                  is_halt
);

  opcode_t op;

  assign op      = opcode_t'(ir[OP_MSB:OP_LSB]);
  assign rs_addr = ir[RS_MSB:RS_LSB];
  assign rt_addr = ir[RT_MSB:RT_LSB];
  assign rd_addr = ir[RD_MSB:RD_LSB];

  // Opcode to control bits; unknown opcodes fall through as NOP
  always_comb begin
    alu_op      = AluAdd;
    alu_src_imm = 1'b0;
    wb_sel_imm  = 1'b0;
    imm         = sext6(ir[IMM6_MSB:0]);
    writes_rd   = 1'b0;
    is_bz       = 1'b0;
    is_jr7      = 1'b0;
    is_halt     = 1'b0;
    case (op)
      OpAdd: begin alu_op = AluAdd; writes_rd = 1'b1; end
      OpSub: begin alu_op = AluSub; writes_rd = 1'b1; end
      OpAnd: begin alu_op = AluAnd; writes_rd = 1'b1; end
      OpOr:  begin alu_op = AluOr;  writes_rd = 1'b1; end
      OpXor: begin alu_op = AluXor; writes_rd = 1'b1; end
      OpAddi: begin
        alu_src_imm = 1'b1;
        writes_rd   = 1'b1;
      end
      OpLdi: begin
        wb_sel_imm = 1'b1;
        imm        = DATA_W'(ir[IMM8_MSB:0]);
        writes_rd  = 1'b1;
      end
`ifdef BRANCH_EN
      OpBz:  is_bz  = 1'b1;
      OpJr7: is_jr7 = 1'b1;
`endif
      OpHalt: is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK control FSM owning the program counter.
// Optional macro BRANCH_EN (handled in instr_decode) enables BZ and JR7.
// PC_W is assumed to be at most 16.
module control_unit
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic            clock,
  input logic            reset,
  control_unit_if.master bus
);

  state_t                state_q, state_d;
  logic [PC_W-1:0]       pc_q, pc_d;
  logic [DATA_W-1:0]     ir_q;
  logic [REG_ADDR_W-1:0] rs_addr_q, rt_addr_q, rd_addr_q;
  alu_op_t               alu_op_q;
  logic                  alu_src_imm_q, wb_sel_imm_q;
  logic [DATA_W-1:0]     imm_q;
  logic                  writes_q, bz_q, jr7_q, halt_q;
  logic                  taken_q;
  logic [PC_W-1:0]       r7_q;

  logic [REG_ADDR_W-1:0] dec_rs, dec_rt, dec_rd;
  alu_op_t               dec_alu_op;
  logic                  dec_src_imm, dec_wb_imm, dec_writes, dec_bz, dec_jr7, dec_halt;
  logic [DATA_W-1:0]     dec_imm;

  instr_decode u_decode (
    .ir          (ir_q),
    .rs_addr     (dec_rs),
    .rt_addr     (dec_rt),
    .rd_addr     (dec_rd),
    .alu_op      (dec_alu_op),
    .alu_src_imm (dec_src_imm),
    .wb_sel_imm  (dec_wb_imm),
    .imm         (dec_imm),
    .writes_rd   (dec_writes),
    .is_bz       (dec_bz),
    .is_jr7      (dec_jr7),
    .is_halt     (dec_halt)
  );

  // Next state and pc; pc only moves at the end of WRITEBACK
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      StFetch:     if (bus.instr_valid) state_d = StDecode;
      StDecode:    state_d = StExecute;
      StExecute:   state_d = StWriteback;
      StWriteback: begin
        if (halt_q) begin
          state_d = StHalted;
        end else begin
          state_d = StFetch;
          if (jr7_q)        pc_d = r7_q;
          else if (taken_q) pc_d = pc_q + PC_W'(signed'(imm_q));
          else              pc_d = pc_q + PC_W'(1);
        end
      end
      StHalted:    state_d = StHalted;
      default:     state_d = StFetch;
    endcase
  end

  // FSM state and pc
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Instruction capture on handshake, decoded controls held from DECODE through WRITEBACK
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ir_q          <= '0;
      rs_addr_q     <= '0;
      rt_addr_q     <= '0;
      rd_addr_q     <= '0;
      alu_op_q      <= AluAdd;
      alu_src_imm_q <= 1'b0;
      wb_sel_imm_q  <= 1'b0;
      imm_q         <= '0;
      writes_q      <= 1'b0;
      bz_q          <= 1'b0;
      jr7_q         <= 1'b0;
      halt_q        <= 1'b0;
    end else if (state_q == StFetch && bus.instr_valid) begin
      ir_q <= bus.instr;
    end else if (state_q == StDecode) begin
      rs_addr_q     <= dec_rs;
      rt_addr_q     <= dec_rt;
      rd_addr_q     <= dec_rd;
      alu_op_q      <= dec_alu_op;
      alu_src_imm_q <= dec_src_imm;
      wb_sel_imm_q  <= dec_wb_imm;
      imm_q         <= dec_imm;
      writes_q      <= dec_writes;
      bz_q          <= dec_bz;
      jr7_q         <= dec_jr7;
      halt_q        <= dec_halt;
    end
  end

  // Branch condition and jump target sampled at the end of EXECUTE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      taken_q <= 1'b0;
      r7_q    <= '0;
    end else if (state_q == StExecute) begin
      taken_q <= bz_q && (bus.rs_data == '0);
      r7_q    <= bus.r7_data[PC_W-1:0];
    end
  end

  // Outputs; rf_write decodes from state so reset kills it immediately
  always_comb begin
    bus.instr_ready = (state_q == StFetch);
    bus.halted      = (state_q == StHalted);
    bus.rf_write    = (state_q == StWriteback) && writes_q;
    bus.pc          = pc_q;
    bus.rs_addr     = rs_addr_q;
    bus.rt_addr     = rt_addr_q;
    bus.rd_addr     = rd_addr_q;
    bus.alu_op      = alu_op_q;
    bus.alu_src_imm = alu_src_imm_q;
    bus.wb_sel_imm  = wb_sel_imm_q;
    bus.imm         = imm_q;
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: driver pushes expectations, negedge monitor checks them.
module tb_control_unit;
  import cpu_pkg::*;

`ifdef BRANCH_EN
  localparam bit BranchEn = 1'b1;
`else
  localparam bit BranchEn = 1'b0;
`endif

  typedef struct {
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  alu;
    logic        src_imm;
    logic        wb_imm;
    logic [15:0] imm;
    bit          is_ldi;
  } wb_t;

  logic clock;
  logic reset;
  control_unit_if #(.PC_W(8)) bus ();

  control_unit #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cycle    = 0;
  int          last_hs  = 0;
  logic [7:0]  m_pc;
  logic [7:0]  pc_exp_q[$];
  wb_t         wb_exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural next pc from the ISA rules
  function automatic logic [7:0] model_next_pc(input logic [15:0] ins, input logic [7:0] pc,
                                               input logic [15:0] rs, input logic [15:0] r7);
    logic [7:0] off;
    off = {{2{ins[5]}}, ins[5:0]};
    if (BranchEn && ins[15:12] == 4'h9) return r7[7:0];
    if (BranchEn && ins[15:12] == 4'h8 && rs == 16'h0) return pc + off;
    return pc + 8'd1;
  endfunction

  // Monitor: checks fetch pc on each handshake and every register write against the queues
  always @(negedge clock) begin
    cycle++;
    if (!reset && bus.instr_valid && bus.instr_ready) begin
      if (pc_exp_q.size() == 0) check("unexpected_fetch", 1, 0);
      else check("fetch_pc", {24'h0, bus.pc}, {24'h0, pc_exp_q.pop_front()});
      last_hs = cycle;
    end
    if (bus.rf_write) begin
      if (wb_exp_q.size() == 0) begin
        check("unexpected_rf_write", 1, 0);
      end else begin
        wb_t e;
        e = wb_exp_q.pop_front();
        check("wb_latency", cycle - last_hs, 3);
        check("wb_rd_addr", {29'h0, bus.rd_addr}, {29'h0, e.rd});
        check("wb_sel_imm", {31'h0, bus.wb_sel_imm}, {31'h0, e.wb_imm});
        if (e.is_ldi) begin
          check("wb_imm_ldi", {16'h0, bus.imm}, {16'h0, e.imm});
        end else begin
          check("wb_rs_addr", {29'h0, bus.rs_addr}, {29'h0, e.rs});
          check("wb_alu_op", {29'h0, bus.alu_op}, {29'h0, e.alu});
          check("wb_alu_src_imm", {31'h0, bus.alu_src_imm}, {31'h0, e.src_imm});
          if (e.src_imm) check("wb_imm_addi", {16'h0, bus.imm}, {16'h0, e.imm});
          else check("wb_rt_addr", {29'h0, bus.rt_addr}, {29'h0, e.rt});
        end
      end
    end
  end

  // Issue one instruction from posedge+1 in FETCH; optionally wait for the next FETCH
  task automatic issue(input logic [15:0] ins, input logic [15:0] rs, input logic [15:0] r7,
                       input bit await_fetch);
    logic [3:0] op;
    wb_t        e;
    int         n;
    op = ins[15:12];
    if ($urandom_range(3) == 0) begin
      bus.instr_valid = 1'b0;
      bus.instr       = 16'($urandom);
      @(posedge clock); #1;
    end
    bus.instr       = ins;
    bus.rs_data     = rs;
    bus.r7_data     = r7;
    bus.instr_valid = 1'b1;
    pc_exp_q.push_back(m_pc);
    if (op >= 4'd1 && op <= 4'd7) begin
      e.rd      = ins[11:9];
      e.rs      = ins[8:6];
      e.rt      = ins[5:3];
      e.alu     = (op <= 4'd5) ? 3'(op - 4'd1) : 3'd0;
      e.src_imm = (op == 4'd6);
      e.wb_imm  = (op == 4'd7);
      e.imm     = (op == 4'd7) ? {8'h00, ins[7:0]} : {{10{ins[5]}}, ins[5:0]};
      e.is_ldi  = (op == 4'd7);
      wb_exp_q.push_back(e);
    end
    if (op != 4'hF) m_pc = model_next_pc(ins, m_pc, rs, r7);
    @(posedge clock); #1;
    // Garbage on instr/instr_valid outside FETCH must be ignored
    bus.instr       = 16'($urandom);
    bus.instr_valid = 1'($urandom);
    if (await_fetch) begin
      n = 0;
      while (!bus.instr_ready && n < 10) begin
        @(posedge clock); #1;
        n++;
      end
      bus.instr_valid = 1'b0;
      check("return_to_fetch", {31'h0, bus.instr_ready}, 1);
    end
  endtask

  task automatic goto_pc(input logic [7:0] target);
    int n;
    n = 0;
    while (m_pc != target && n < 300) begin
      issue(16'h0000, 16'h0, 16'h0, 1'b1);
      n++;
    end
  endtask

  initial begin
    logic [15:0] ins;
    logic [15:0] rs;
    bus.instr       = 16'h0;
    bus.instr_valid = 1'b0;
    bus.rs_data     = 16'h0;
    bus.r7_data     = 16'h0;
    reset           = 1'b1;
    m_pc            = 8'h00;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_pc", {24'h0, bus.pc}, 0);
    check("rst_instr_ready", {31'h0, bus.instr_ready}, 1);
    check("rst_rf_write", {31'h0, bus.rf_write}, 0);
    check("rst_halted", {31'h0, bus.halted}, 0);
    check("rst_imm", {16'h0, bus.imm}, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Directed cases
    issue(16'h7001, 16'h0, 16'h0, 1'b1);   // LDI r0,#1
    issue(16'h1E50, 16'h0, 16'h0, 1'b1);   // ADD r7,r1,r2
    issue(16'h66FF, 16'h0, 16'h0, 1'b1);   // ADDI r3,r3,#-1
    goto_pc(8'h10);
    issue(16'h807E, 16'h0, 16'h0, 1'b1);   // BZ r1,#-2 taken
    goto_pc(8'h10);
    issue(16'h807E, 16'h5, 16'h0, 1'b1);   // BZ r1,#-2 not taken
    issue(16'h9000, 16'h0, 16'h00AB, 1'b1); // JR7
    issue(16'h8000, 16'h0, 16'h0, 1'b1);   // BZ offset 0
    goto_pc(8'hFF);
    issue(16'h0000, 16'h0, 16'h0, 1'b1);   // pc wraps 0xFF -> 0x00
    issue(16'h807F, 16'h0, 16'h0, 1'b1);   // BZ -1 at pc 0
    check("model_pc_sync", {24'h0, bus.pc}, {24'h0, m_pc});

    // Random instructions, HALT excluded
    for (int i = 0; i < 300; i++) begin
      ins = {4'($urandom_range(14)), 12'($urandom)};
      rs  = ($urandom_range(1) == 0) ? 16'h0 : 16'($urandom);
      issue(ins, rs, 16'($urandom), 1'b1);
    end

    // HALT, then keep offering instructions
    issue(16'hF000, 16'h0, 16'h0, 1'b0);
    bus.instr_valid = 1'b1;
    repeat (3) begin @(posedge clock); #1; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check("halted", {31'h0, bus.halted}, 1);
      check("halt_instr_ready", {31'h0, bus.instr_ready}, 0);
      check("halt_pc_frozen", {24'h0, bus.pc}, {24'h0, m_pc});
      check("halt_rf_write", {31'h0, bus.rf_write}, 0);
    end

    // Reset out of HALTED, then reset again mid-DECODE of an LDI
    @(posedge clock); #1;
    reset = 1'b1;
    bus.instr_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    m_pc  = 8'h00;
    check("post_halt_rst_halted", {31'h0, bus.halted}, 0);
    issue(16'h7A55, 16'h0, 16'h0, 1'b0);
    reset = 1'b1;
    pc_exp_q.delete();
    wb_exp_q.delete();
    #1;
    check("mid_rst_pc", {24'h0, bus.pc}, 0);
    check("mid_rst_instr_ready", {31'h0, bus.instr_ready}, 1);
    check("mid_rst_rf_write", {31'h0, bus.rf_write}, 0);
    bus.instr_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (8) @(posedge clock);
    @(negedge clock);
    check("final_pc", {24'h0, bus.pc}, 0);
    check("pc_queue_drained", pc_exp_q.size(), 0);
    check("wb_queue_drained", wb_exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
